// File: rtl/hilbert_pkg.sv
// Shared types and constants for the HilbertFilter chain (phase format, CORDIC tables, FSM states).
// Phase values are signed Q8.10 radians, PHASE_W bits wide.
package hilbert_pkg;

  localparam int PHASE_W    = 19;
  localparam int PHASE_FRAC = 10;
  localparam int PI_Q16     = 205887;
  localparam int PI_Q10     = 3217;

  typedef enum logic [1:0] {IDLE, PRE, ROT, OUT} state_t;

  // atan(2^-i) in Q.16 radians
  function automatic int atan_q16(input logic [3:0] i);
    int a;
    a = 0;
    case (i)
      4'd0:  a = 51472;
      4'd1:  a = 30386;
      4'd2:  a = 16055;
      4'd3:  a = 8150;
      4'd4:  a = 4091;
      4'd5:  a = 2047;
      4'd6:  a = 1024;
      4'd7:  a = 512;
      4'd8:  a = 256;
      4'd9:  a = 128;
      4'd10: a = 64;
      4'd11: a = 32;
      4'd12: a = 16;
      4'd13: a = 8;
      4'd14: a = 4;
      4'd15: a = 2;
      default: a = 0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational vectoring-mode CORDIC micro-rotation, driving y toward zero.
// Shifts are arithmetic; all three outputs are computed from the old x/y/z.
module cordic_stage
  import hilbert_pkg::*;
#(
  parameter int XW    = 20,
  parameter int ZW    = 20,
  parameter int ZFRAC = 16
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic signed [ZW-1:0] z,
  input  logic        [3:0]    i,
  output logic signed [XW-1:0] x_nxt,
  output logic signed [XW-1:0] y_nxt,
  output logic signed [ZW-1:0] z_nxt
);

  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;
  logic signed [ZW-1:0] a;

  always_comb begin
    xs = x >>> i;
    ys = y >>> i;
    a  = ZW'(atan_q16(i) >>> (16 - ZFRAC));
    if (!y[XW-1]) begin
      x_nxt = x + ys;
      y_nxt = y - xs;
      z_nxt = z + a;
    end else begin
      x_nxt = x - ys;
      y_nxt = y + xs;
      z_nxt = z - a;
    end
  end

endmodule

// File: rtl/phase_cordic.sv
// Iterative vectoring CORDIC: phase = atan2(yin, xin), Q8.10 radians, done ITER+2 cycles after sample.
// PHASE_CORDIC_MAG_EN adds the gain-uncorrected magnitude output mag; samples arriving while busy are dropped.
module phase_cordic
  import hilbert_pkg::*;
#(
  parameter int ITER  = 14,
  parameter int IN_W  = 18,
  parameter int ZFRAC = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      sample,
  input  logic signed [IN_W-1:0]    xin,
  input  logic signed [IN_W-1:0]    yin,
  output logic                      busy,
  output logic                      done,
  output logic signed [PHASE_W-1:0] phase
`ifdef PHASE_CORDIC_MAG_EN
  ,
  output logic        [IN_W:0]      mag
`endif
);

  localparam int XW = IN_W + 2;
  localparam int ZW = ZFRAC + 4;
  localparam logic signed [ZW-1:0] PI_Z = ZW'(PI_Q16 >>> (16 - ZFRAC));
  localparam logic signed [ZW-1:0] RND  = ZW'(1 << (ZFRAC - 11));
  localparam logic signed [ZW-1:0] PMAX = ZW'(PI_Q10);

  state_t state, state_nxt;
  logic [3:0]           cnt;
  logic signed [XW-1:0] x, y, x_rot, y_rot;
  logic signed [ZW-1:0] z, z_rot, z_rnd;
  logic signed [PHASE_W-1:0] phase_sat;
  logic                 zero_in;

  cordic_stage #(.XW(XW), .ZW(ZW), .ZFRAC(ZFRAC)) u_stage (
    .x     (x),
    .y     (y),
    .z     (z),
    .i     (cnt),
    .x_nxt (x_rot),
    .y_nxt (y_rot),
    .z_nxt (z_rot)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample) state_nxt = PRE;
      PRE:     state_nxt = ROT;
      ROT:     if (cnt == 4'(ITER - 1)) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    z_rnd = (z + RND) >>> (ZFRAC - 10);
    if (z_rnd > PMAX)       phase_sat = PHASE_W'(PI_Q10);
    else if (z_rnd < -PMAX) phase_sat = -PHASE_W'(PI_Q10);
    else                    phase_sat = z_rnd[PHASE_W-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      zero_in <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      phase   <= '0;
`ifdef PHASE_CORDIC_MAG_EN
      mag     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (sample) begin
          x       <= {{2{xin[IN_W-1]}}, xin};
          y       <= {{2{yin[IN_W-1]}}, yin};
          z       <= '0;
          cnt     <= '0;
          busy    <= 1'b1;
          // a zero vector has no angle; the rotations alone would drift to ~1.74 rad
          zero_in <= (xin == '0) && (yin == '0);
        end
        PRE: begin
          cnt <= '0;
          if (x[XW-1]) begin
            x <= -x;
            y <= -y;
            z <= y[XW-1] ? -PI_Z : PI_Z;
          end else begin
            z <= '0;
          end
        end
        ROT: begin
          x   <= x_rot;
          y   <= y_rot;
          z   <= z_rot;
          cnt <= cnt + 4'd1;
        end
        OUT: begin
          phase <= zero_in ? '0 : phase_sat;
          done  <= 1'b1;
          busy  <= 1'b0;
`ifdef PHASE_CORDIC_MAG_EN
          mag   <= x[IN_W:0];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_cordic.sv
// Directed-vector bench for phase_cordic: latency, busy/done timing, phase values, boundaries, reset abort.
`timescale 1ns/1ps
module tb_phase_cordic;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               sample = 1'b0;
  logic signed [17:0] xin = '0;
  logic signed [17:0] yin = '0;
  logic               busy;
  logic               done;
  logic signed [18:0] phase;
`ifdef PHASE_CORDIC_MAG_EN
  logic        [18:0] mag;
`endif

  int nchk = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  phase_cordic dut (
    .clock  (clock),
    .reset  (reset),
    .sample (sample),
    .xin    (xin),
    .yin    (yin),
    .busy   (busy),
    .done   (done),
    .phase  (phase)
`ifdef PHASE_CORDIC_MAG_EN
    ,
    .mag    (mag)
`endif
  );

  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    nchk++;
    if (got < exp - tol || got > exp + tol) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, got, exp, tol);
    end
  endtask

  // Pulse sample with (xi, yi), optionally a second pulse (ex, ey) at step extra_at,
  // then watch 40 negedges. Step k is the negedge k clock edges after the sample edge.
  task automatic conv(input int xi, input int yi, input int extra_at, input int ex, input int ey,
                      output int lat, output int ndone, output int nbusy);
    @(negedge clock);
    sample = 1'b1;
    xin    = 18'(xi);
    yin    = 18'(yi);
    @(posedge clock);
    lat = -1; ndone = 0; nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      sample = (k == extra_at);
      if (k == extra_at) begin
        xin = 18'(ex);
        yin = 18'(ey);
      end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
    end
    sample = 1'b0;
  endtask

  int lat, nd, nb;

  initial begin
    repeat (3) @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_phase", int'(phase), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    conv(1000, 0, -1, 0, 0, lat, nd, nb);
    check("lat_1000_0", lat, 16);
    check("ndone_1000_0", nd, 1);
    check("nbusy_1000_0", nb, 16);
    check("ph_1000_0", int'(phase), 0, 1);
`ifdef PHASE_CORDIC_MAG_EN
    check("mag_1000_0", int'(mag), 1647, 1);
`endif

    conv(0, 1000, -1, 0, 0, lat, nd, nb);
    check("ph_0_1000", int'(phase), 1608, 2);
    conv(1000, 1000, -1, 0, 0, lat, nd, nb);
    check("ph_1000_1000", int'(phase), 804, 2);
    conv(1000, -1000, -1, 0, 0, lat, nd, nb);
    check("ph_1000_m1000", int'(phase), -804, 2);
    conv(-1000, 0, -1, 0, 0, lat, nd, nb);
    check("ph_m1000_0", int'(phase), 3217);
    conv(-1000, -1, -1, 0, 0, lat, nd, nb);
    check("ph_m1000_m1", int'(phase), -3216, 1);
    conv(0, 0, -1, 0, 0, lat, nd, nb);
    check("lat_0_0", lat, 16);
    check("ph_0_0", int'(phase), 0);
    conv(-131072, -131072, -1, 0, 0, lat, nd, nb);
    check("ph_min_min", int'(phase), -2413, 2);
    conv(131071, -131072, -1, 0, 0, lat, nd, nb);
    check("ph_max_min", int'(phase), -804, 2);

    // second sample 5 cycles in must be dropped
    conv(1000, 1000, 5, -1000, 0, lat, nd, nb);
    check("ign_ndone", nd, 1);
    check("ign_phase", int'(phase), 804, 2);

    // sample the cycle after done is accepted
    conv(1000, -1000, 17, 0, 1000, lat, nd, nb);
    check("b2b_lat", lat, 16);
    check("b2b_ndone", nd, 2);
    check("b2b_phase", int'(phase), 1608, 2);

    // reset pulse just before iteration 6
    @(negedge clock);
    sample = 1'b1; xin = 18'sd1000; yin = 18'sd0;
    @(posedge clock);
    @(negedge clock);
    sample = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_phase", int'(phase), 0);
    @(negedge clock);
    reset = 1'b1;
    nd = 0;
    repeat (30) begin
      @(negedge clock);
      if (done) nd++;
    end
    check("abort_ndone", nd, 0);
    check("abort_phase_hold", int'(phase), 0);
    check("abort_idle_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
